// File: rtl/arp_resolve_ctrl.sv
// arp_resolve_ctrl: turns IP-to-MAC resolve requests from two round-robin
// requesters into ARP table lookups and ARP requests, retries on reply
// timeout and returns either the resolved MAC or a fail status.
// Optional statistics counters are built when ARP_RESOLVE_STATS_EN is defined.
`timescale 1ns/1ps

module arp_resolve_ctrl #(
    parameter int          P_LOOKUP_WAIT = 4,
    parameter logic [31:0] P_TIMEOUT_CYC = 32'd15625,
    parameter int          P_MAX_RETRY   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_ip,
    output logic        o_req0_ready,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_ip,
    output logic        o_req1_ready,
    output logic [31:0] o_seek_ip,
    output logic        o_seek_valid,
    input  logic [47:0] i_seek_mac,
    input  logic        i_seek_mac_valid,
    output logic        o_arp_active,
    output logic [31:0] o_arp_active_dst_ip,
    input  logic [31:0] i_recv_target_ip,
    input  logic [47:0] i_recv_target_mac,
    input  logic        i_recv_target_valid,
    output logic        o_rsp_valid,
    output logic        o_rsp_id,
    output logic        o_rsp_ok,
    output logic [47:0] o_rsp_mac,
`ifdef ARP_RESOLVE_STATS_EN
    output logic [15:0] o_stat_req_cnt,
    output logic [15:0] o_stat_tx_cnt,
    output logic [15:0] o_stat_fail_cnt,
`endif
    output logic        o_busy
);

    localparam int          LW           = (P_LOOKUP_WAIT < 1) ? 1 : $clog2(P_LOOKUP_WAIT + 1);
    localparam logic [LW-1:0] LOOKUP_LAST = LW'(P_LOOKUP_WAIT);
    localparam logic [31:0] TIMEOUT_LAST = P_TIMEOUT_CYC - 32'd1;
    localparam logic [3:0]  MAX_RETRY    = 4'(P_MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_SEND,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [31:0]    ip_q;
    logic           id_q;
    logic           rr_ptr;
    logic [47:0]    mac_q;
    logic           ok_q;
    logic [3:0]     retry_q;
    logic [31:0]    timer_q;
    logic [LW-1:0]  lk_cnt_q;
    logic           grant0;
    logic           grant1;
    logic           reply_match;

    assign reply_match = i_recv_target_valid && (i_recv_target_ip == ip_q);

    // Round-robin arbitration in IDLE: rr_ptr names the requester preferred on a tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i_rst && (state == S_IDLE)) begin
            if (i_req0_valid && (!i_req1_valid || !rr_ptr)) begin
                grant0 = 1'b1;
            end else if (i_req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-driven outputs
    always_comb begin
        state_nxt           = state;
        o_req0_ready        = grant0;
        o_req1_ready        = grant1;
        o_seek_valid        = 1'b0;
        o_seek_ip           = 32'h0;
        o_arp_active        = 1'b0;
        o_arp_active_dst_ip = 32'h0;
        o_rsp_valid         = 1'b0;
        o_rsp_id            = 1'b0;
        o_rsp_ok            = 1'b0;
        o_rsp_mac           = 48'h0;
        o_busy              = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lk_cnt_q == '0) begin
                    o_seek_valid = 1'b1;
                    o_seek_ip    = ip_q;
                end
                if (i_seek_mac_valid) begin
                    state_nxt = (i_seek_mac != 48'h0) ? S_RESP : S_SEND;
                end else if (lk_cnt_q == LOOKUP_LAST) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                o_arp_active        = 1'b1;
                o_arp_active_dst_ip = ip_q;
                state_nxt           = S_WAIT;
            end
            S_WAIT: begin
                if (reply_match) begin
                    state_nxt = S_RESP;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_nxt = (retry_q < MAX_RETRY) ? S_SEND : S_RESP;
                end
            end
            S_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_id    = id_q;
                o_rsp_ok    = ok_q;
                o_rsp_mac   = ok_q ? mac_q : 48'h0;
                state_nxt   = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transaction context: latched request, result, retry/timer/lookup counters
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ip_q     <= 32'h0;
            id_q     <= 1'b0;
            rr_ptr   <= 1'b0;
            mac_q    <= 48'h0;
            ok_q     <= 1'b0;
            retry_q  <= 4'd0;
            timer_q  <= 32'd0;
            lk_cnt_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        ip_q     <= grant1 ? i_req1_ip : i_req0_ip;
                        id_q     <= grant1;
                        rr_ptr   <= grant0;
                        mac_q    <= 48'h0;
                        ok_q     <= 1'b0;
                        retry_q  <= 4'd0;
                        timer_q  <= 32'd0;
                        lk_cnt_q <= '0;
                    end
                end
                S_LOOKUP: begin
                    if (lk_cnt_q != LOOKUP_LAST) begin
                        lk_cnt_q <= lk_cnt_q + LW'(1);
                    end
                    if (i_seek_mac_valid && (i_seek_mac != 48'h0)) begin
                        mac_q <= i_seek_mac;
                        ok_q  <= 1'b1;
                    end
                end
                S_SEND: begin
                    retry_q <= retry_q + 4'd1;
                    timer_q <= 32'd0;
                end
                S_WAIT: begin
                    timer_q <= timer_q + 32'd1;
                    if (reply_match) begin
                        mac_q <= i_recv_target_mac;
                        ok_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ARP_RESOLVE_STATS_EN
    logic [15:0] stat_req_q;
    logic [15:0] stat_tx_q;
    logic [15:0] stat_fail_q;

    // Saturating counters of grants, ARP requests sent and failed responses
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            stat_req_q  <= 16'h0;
            stat_tx_q   <= 16'h0;
            stat_fail_q <= 16'h0;
        end else begin
            if ((grant0 || grant1) && (stat_req_q != 16'hFFFF)) begin
                stat_req_q <= stat_req_q + 16'd1;
            end
            if ((state == S_SEND) && (stat_tx_q != 16'hFFFF)) begin
                stat_tx_q <= stat_tx_q + 16'd1;
            end
            if ((state == S_RESP) && !ok_q && (stat_fail_q != 16'hFFFF)) begin
                stat_fail_q <= stat_fail_q + 16'd1;
            end
        end
    end

    assign o_stat_req_cnt  = stat_req_q;
    assign o_stat_tx_cnt   = stat_tx_q;
    assign o_stat_fail_cnt = stat_fail_q;
`endif

endmodule

// File: tb/tb_arp_resolve_ctrl.sv
// tb_arp_resolve_ctrl: randomized and directed checks of arp_resolve_ctrl
// against a behavioural model of the resolve outcome (hit / reply / fail).
`timescale 1ns/1ps

module tb_arp_resolve_ctrl;

    localparam int          MAX_RETRY = 3;
    localparam logic [31:0] IP_A      = 32'hC0A86464;  // 192.168.100.100
    localparam logic [31:0] IP_DECOY  = 32'hC0A86407;  // 192.168.100.7

    logic        i_clk;
    logic        i_rst;
    logic        i_req0_valid;
    logic [31:0] i_req0_ip;
    logic        o_req0_ready;
    logic        i_req1_valid;
    logic [31:0] i_req1_ip;
    logic        o_req1_ready;
    logic [31:0] o_seek_ip;
    logic        o_seek_valid;
    logic [47:0] i_seek_mac;
    logic        i_seek_mac_valid;
    logic        o_arp_active;
    logic [31:0] o_arp_active_dst_ip;
    logic [31:0] i_recv_target_ip;
    logic [47:0] i_recv_target_mac;
    logic        i_recv_target_valid;
    logic        o_rsp_valid;
    logic        o_rsp_id;
    logic        o_rsp_ok;
    logic [47:0] o_rsp_mac;
    logic        o_busy;
`ifdef ARP_RESOLVE_STATS_EN
    logic [15:0] o_stat_req_cnt;
    logic [15:0] o_stat_tx_cnt;
    logic [15:0] o_stat_fail_cnt;
`endif

    arp_resolve_ctrl #(
        .P_LOOKUP_WAIT (4),
        .P_TIMEOUT_CYC (32'd20),
        .P_MAX_RETRY   (MAX_RETRY)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_req0_valid        (i_req0_valid),
        .i_req0_ip           (i_req0_ip),
        .o_req0_ready        (o_req0_ready),
        .i_req1_valid        (i_req1_valid),
        .i_req1_ip           (i_req1_ip),
        .o_req1_ready        (o_req1_ready),
        .o_seek_ip           (o_seek_ip),
        .o_seek_valid        (o_seek_valid),
        .i_seek_mac          (i_seek_mac),
        .i_seek_mac_valid    (i_seek_mac_valid),
        .o_arp_active        (o_arp_active),
        .o_arp_active_dst_ip (o_arp_active_dst_ip),
        .i_recv_target_ip    (i_recv_target_ip),
        .i_recv_target_mac   (i_recv_target_mac),
        .i_recv_target_valid (i_recv_target_valid),
        .o_rsp_valid         (o_rsp_valid),
        .o_rsp_id            (o_rsp_id),
        .o_rsp_ok            (o_rsp_ok),
        .o_rsp_mac           (o_rsp_mac),
`ifdef ARP_RESOLVE_STATS_EN
        .o_stat_req_cnt      (o_stat_req_cnt),
        .o_stat_tx_cnt       (o_stat_tx_cnt),
        .o_stat_fail_cnt     (o_stat_fail_cnt),
`endif
        .o_busy              (o_busy)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    logic [47:0] table_mem [logic [31:0]];
    bit          table_silent = 0;

    int          arp_cnt = 0;
    int          rsp_cnt = 0;
    int          arp_cyc_q[$];
    int          txn_arp_base = 0;
    int          reply_attempt = 0;
    int          reply_delay = 0;
    logic [31:0] reply_ip = 32'h0;
    logic [47:0] reply_mac = 48'h0;
    bit          decoy_en = 0;

    // Free-running clock and cycle counter
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    // ARP table model: answers a seek one cycle later, unknown IPs read as 48'h0
    initial begin
        bit          pend;
        logic [31:0] pip;
        pend = 0;
        pip = 32'h0;
        i_seek_mac_valid = 1'b0;
        i_seek_mac = 48'h0;
        forever begin
            @(posedge i_clk);
            #1;
            i_seek_mac_valid = 1'b0;
            i_seek_mac = 48'h0;
            if (pend) begin
                i_seek_mac_valid = 1'b1;
                i_seek_mac = table_mem.exists(pip) ? table_mem[pip] : 48'h0;
                pend = 0;
            end
            if (o_seek_valid && !table_silent) begin
                pend = 1;
                pip = o_seek_ip;
            end
        end
    end

    // Remote host model: counts ARP requests and replies after a chosen attempt/delay
    initial begin
        int cd;
        int dcd;
        cd = 0;
        dcd = 0;
        i_recv_target_valid = 1'b0;
        i_recv_target_ip = 32'h0;
        i_recv_target_mac = 48'h0;
        forever begin
            @(posedge i_clk);
            #1;
            i_recv_target_valid = 1'b0;
            i_recv_target_ip = 32'h0;
            i_recv_target_mac = 48'h0;
            if (dcd > 0) begin
                dcd--;
                if (dcd == 0) begin
                    i_recv_target_valid = 1'b1;
                    i_recv_target_ip = IP_DECOY;
                    i_recv_target_mac = 48'hDEADBEEF0007;
                end
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    i_recv_target_valid = 1'b1;
                    i_recv_target_ip = reply_ip;
                    i_recv_target_mac = reply_mac;
                end
            end
            if (o_rsp_valid) rsp_cnt++;
            if (o_arp_active) begin
                arp_cnt++;
                arp_cyc_q.push_back(cyc);
                if ((arp_cnt - txn_arp_base) == reply_attempt) cd = reply_delay;
                if (decoy_en) dcd = 3;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset();
        i_rst = 1'b0;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
    endtask

    task automatic issue(input bit id, input logic [31:0] ip, output bit granted, output int gcyc);
        granted = 0;
        gcyc = 0;
        if (id) begin
            i_req1_valid = 1'b1;
            i_req1_ip = ip;
        end else begin
            i_req0_valid = 1'b1;
            i_req0_ip = ip;
        end
        for (int i = 0; i < 50 && !granted; i++) begin
            @(negedge i_clk);
            if (id ? o_req1_ready : o_req0_ready) begin
                granted = 1;
                gcyc = cyc;
            end
            @(posedge i_clk);
            #1;
        end
        if (id) i_req1_valid = 1'b0;
        else i_req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit got, output bit rid, output bit rok, output logic [47:0] rmac, output int rcyc);
        got = 0;
        rid = 0;
        rok = 0;
        rmac = 48'h0;
        rcyc = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge i_clk);
            if (o_rsp_valid) begin
                got = 1;
                rid = o_rsp_id;
                rok = o_rsp_ok;
                rmac = o_rsp_mac;
                rcyc = cyc;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_txn(input bit id, input logic [31:0] ip, output bit got, output bit rid,
                           output bit rok, output logic [47:0] rmac, output int lat, output int arps);
        bit granted;
        int gcyc;
        int rcyc;
        txn_arp_base = arp_cnt;
        issue(id, ip, granted, gcyc);
        got = 0;
        rid = 0;
        rok = 0;
        rmac = 48'h0;
        rcyc = 0;
        if (granted) wait_rsp(got, rid, rok, rmac, rcyc);
        lat = rcyc - gcyc;
        arps = arp_cnt - txn_arp_base;
    endtask

    task automatic test_reset();
        i_req0_valid = 1'b1;
        i_req0_ip = IP_A;
        i_req1_valid = 1'b0;
        i_req1_ip = 32'h0;
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_req0_ready !== 1'b0) $display("[TB] FAIL reset_ready: got %b, expected 0", o_req0_ready);
        else passes++;
        @(posedge i_clk);
        #1;
        i_req0_valid = 1'b0;
        apply_reset();
        @(negedge i_clk);
        checks++;
        if ({o_busy, o_rsp_valid, o_seek_valid, o_arp_active, o_req0_ready, o_req1_ready, o_rsp_id, o_rsp_ok} !== 8'h00)
            $display("[TB] FAIL reset_ctrl: got %b, expected 00000000",
                     {o_busy, o_rsp_valid, o_seek_valid, o_arp_active, o_req0_ready, o_req1_ready, o_rsp_id, o_rsp_ok});
        else passes++;
        checks++;
        if ({o_seek_ip, o_arp_active_dst_ip, o_rsp_mac} !== 112'h0)
            $display("[TB] FAIL reset_data: got %h %h %h, expected zeros", o_seek_ip, o_arp_active_dst_ip, o_rsp_mac);
        else passes++;
`ifdef ARP_RESOLVE_STATS_EN
        checks++;
        if ({o_stat_req_cnt, o_stat_tx_cnt, o_stat_fail_cnt} !== 48'h0)
            $display("[TB] FAIL reset_stats: got %h %h %h, expected zeros", o_stat_req_cnt, o_stat_tx_cnt, o_stat_fail_cnt);
        else passes++;
`endif
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_hit();
        bit got, rid, rok;
        logic [47:0] rmac;
        int lat, arps;
        table_mem[IP_A] = 48'hAABBCCDDEEFF;
        reply_attempt = 0;
        decoy_en = 0;
        run_txn(1'b0, IP_A, got, rid, rok, rmac, lat, arps);
        checks++;
        if (got !== 1'b1) $display("[TB] FAIL hit_rsp: got %b, expected 1 (response within bound)", got);
        else passes++;
        checks++;
        if ({rid, rok} !== 2'b01) $display("[TB] FAIL hit_id_ok: got %b, expected 01", {rid, rok});
        else passes++;
        checks++;
        if (rmac !== 48'hAABBCCDDEEFF) $display("[TB] FAIL hit_mac: got %h, expected aabbccddeeff", rmac);
        else passes++;
        checks++;
        if (arps !== 0) $display("[TB] FAIL hit_arp_count: got %0d, expected 0", arps);
        else passes++;
        checks++;
        if (lat !== 3) $display("[TB] FAIL hit_latency: got %0d, expected 3", lat);
        else passes++;
    endtask

    task automatic test_miss_reply();
        bit got, rid, rok;
        logic [47:0] rmac;
        int lat, arps;
        reply_attempt = 1;
        reply_delay = 10;
        reply_ip = 32'h0A000005;
        reply_mac = 48'h112233445566;
        decoy_en = 0;
        run_txn(1'b0, 32'h0A000005, got, rid, rok, rmac, lat, arps);
        checks++;
        if ({got, rok} !== 2'b11) $display("[TB] FAIL miss_reply_ok: got %b, expected 11", {got, rok});
        else passes++;
        checks++;
        if (rmac !== 48'h112233445566) $display("[TB] FAIL miss_reply_mac: got %h, expected 112233445566", rmac);
        else passes++;
        checks++;
        if (arps !== 1) $display("[TB] FAIL miss_reply_arp_count: got %0d, expected 1", arps);
        else passes++;
    endtask

    task automatic test_timeout();
        bit got, rid, rok;
        logic [47:0] rmac;
        int lat, arps, base;
        reply_attempt = 0;
        decoy_en = 0;
        base = arp_cyc_q.size();
        run_txn(1'b1, 32'h0A000009, got, rid, rok, rmac, lat, arps);
        checks++;
        if ({got, rid, rok} !== 3'b110) $display("[TB] FAIL timeout_rsp: got %b, expected 110", {got, rid, rok});
        else passes++;
        checks++;
        if (rmac !== 48'h0) $display("[TB] FAIL timeout_mac: got %h, expected 0", rmac);
        else passes++;
        checks++;
        if (arps !== MAX_RETRY) $display("[TB] FAIL timeout_arp_count: got %0d, expected %0d", arps, MAX_RETRY);
        else passes++;
        if (arp_cyc_q.size() >= base + 3) begin
            checks++;
            if ((arp_cyc_q[base+1] - arp_cyc_q[base]) !== 21 || (arp_cyc_q[base+2] - arp_cyc_q[base+1]) !== 21)
                $display("[TB] FAIL timeout_spacing: got %0d,%0d, expected 21,21",
                         arp_cyc_q[base+1] - arp_cyc_q[base], arp_cyc_q[base+2] - arp_cyc_q[base+1]);
            else passes++;
        end
    endtask

    task automatic test_filter_tie();
        bit got, rid, rok;
        logic [47:0] rmac;
        int lat, arps;
        table_mem.delete(IP_A);
        for (int k = 1; k <= MAX_RETRY; k += 2) begin
            reply_attempt = k;
            reply_delay = 20;
            reply_ip = IP_A;
            reply_mac = 48'h0A0B0C0D0E00 + 48'(k);
            decoy_en = 1;
            run_txn(1'b0, IP_A, got, rid, rok, rmac, lat, arps);
            checks++;
            if ({got, rok} !== 2'b11) $display("[TB] FAIL tie_ok_%0d: got %b, expected 11", k, {got, rok});
            else passes++;
            checks++;
            if (rmac !== (48'h0A0B0C0D0E00 + 48'(k))) $display("[TB] FAIL tie_mac_%0d: got %h, expected %h", k, rmac, 48'h0A0B0C0D0E00 + 48'(k));
            else passes++;
            checks++;
            if (arps !== k) $display("[TB] FAIL tie_arp_count_%0d: got %0d, expected %0d", k, arps, k);
            else passes++;
        end
        decoy_en = 0;
    endtask

    task automatic test_arbitration();
        bit got, rid, rok, who, exp_ptr, seen;
        logic [47:0] rmac;
        logic [31:0] ip0, ip1, gip;
        int rcyc;
        reply_attempt = 0;
        apply_reset();
        exp_ptr = 0;
        for (int k = 0; k < 8; k++) table_mem[32'h0A000100 + 32'(k)] = 48'h5000_0000_0000 + 48'(k) + 48'h1;
        ip0 = 32'h0A000100;
        ip1 = 32'h0A000104;
        i_req0_ip = ip0;
        i_req1_ip = ip1;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            seen = 0;
            who = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge i_clk);
                if (o_req0_ready || o_req1_ready) begin
                    seen = 1;
                    who = o_req1_ready;
                end
                @(posedge i_clk);
                #1;
            end
            gip = who ? ip1 : ip0;
            checks++;
            if ({seen, who} !== {1'b1, exp_ptr}) $display("[TB] FAIL arb_grant_%0d: got %b, expected 1%b", t, {seen, who}, exp_ptr);
            else passes++;
            exp_ptr = !who;
            if (who) begin ip1 = ip1 + 32'd1; i_req1_ip = ip1; end
            else begin ip0 = ip0 + 32'd1; i_req0_ip = ip0; end
            wait_rsp(got, rid, rok, rmac, rcyc);
            checks++;
            if ({got, rid, rok} !== {1'b1, who, 1'b1} || rmac !== table_mem[gip])
                $display("[TB] FAIL arb_rsp_%0d: got %b mac %h, expected 1%b1 mac %h", t, {got, rid, rok}, rmac, who, table_mem[gip]);
            else passes++;
        end
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit granted, got, rid, rok;
        logic [47:0] rmac;
        int gcyc, rcyc, rsp_before;
        reply_attempt = 0;
        decoy_en = 0;
        txn_arp_base = arp_cnt;
        issue(1'b0, 32'h0A000021, granted, gcyc);
        for (int i = 0; i < 50 && (arp_cnt - txn_arp_base) < 1; i++) begin
            @(posedge i_clk);
            #1;
        end
        repeat (5) @(posedge i_clk);
        #1;
        rsp_before = rsp_cnt;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b, expected 0", o_busy);
        else passes++;
`ifdef ARP_RESOLVE_STATS_EN
        checks++;
        if ({o_stat_req_cnt, o_stat_tx_cnt, o_stat_fail_cnt} !== 48'h0)
            $display("[TB] FAIL midreset_stats: got %h %h %h, expected zeros", o_stat_req_cnt, o_stat_tx_cnt, o_stat_fail_cnt);
        else passes++;
`endif
        repeat (80) @(posedge i_clk);
        #1;
        checks++;
        if (rsp_cnt !== rsp_before) $display("[TB] FAIL midreset_no_rsp: got %0d responses, expected 0", rsp_cnt - rsp_before);
        else passes++;
        table_mem[IP_A] = 48'h0000DEADCAFE;
        i_req0_ip = IP_A;
        i_req1_ip = 32'h0A000100;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        @(negedge i_clk);
        gcyc = cyc;
        checks++;
        if ({o_req0_ready, o_req1_ready} !== 2'b10) $display("[TB] FAIL midreset_first_grant: got %b, expected 10", {o_req0_ready, o_req1_ready});
        else passes++;
        @(posedge i_clk);
        #1;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        wait_rsp(got, rid, rok, rmac, rcyc);
        checks++;
        if ({got, rid, rok} !== 3'b101 || rmac !== 48'h0000DEADCAFE || (rcyc - gcyc) !== 3)
            $display("[TB] FAIL midreset_hit: got %b mac %h lat %0d, expected 101 mac 0000deadcafe lat 3", {got, rid, rok}, rmac, rcyc - gcyc);
        else passes++;
`ifdef ARP_RESOLVE_STATS_EN
        checks++;
        if ({o_stat_req_cnt, o_stat_tx_cnt, o_stat_fail_cnt} !== {16'd1, 16'd0, 16'd0})
            $display("[TB] FAIL midreset_stats_after: got %h %h %h, expected 0001 0000 0000", o_stat_req_cnt, o_stat_tx_cnt, o_stat_fail_cnt);
        else passes++;
`endif
    endtask

    task automatic test_random();
        bit got, rid, rok, id, exp_ok;
        logic [47:0] rmac, exp_mac, m;
        logic [31:0] ip;
        int lat, arps, scen, exp_arps;
        for (int t = 0; t < 16; t++) begin
            id = 1'($urandom_range(0, 1));
            ip = {8'd10, 8'($urandom_range(1, 250)), 8'($urandom), 8'(t)};
            scen = $urandom_range(0, 3);
            m = {16'($urandom), 32'($urandom)} | 48'h1;
            decoy_en = 1'($urandom_range(0, 1));
            table_silent = (scen == 3);
            reply_ip = ip;
            reply_mac = m;
            reply_delay = $urandom_range(1, 20);
            reply_attempt = (scen == 1 || scen == 3) ? $urandom_range(1, MAX_RETRY) : 0;
            if (table_mem.exists(ip)) table_mem.delete(ip);
            if (scen == 0) table_mem[ip] = m;
            if (scen == 0) begin
                exp_ok = 1; exp_mac = m; exp_arps = 0;
            end else if (reply_attempt > 0) begin
                exp_ok = 1; exp_mac = m; exp_arps = reply_attempt;
            end else begin
                exp_ok = 0; exp_mac = 48'h0; exp_arps = MAX_RETRY;
            end
            run_txn(id, ip, got, rid, rok, rmac, lat, arps);
            checks++;
            if ({got, rid, rok} !== {1'b1, id, exp_ok})
                $display("[TB] FAIL rand_%0d_status: got %b, expected 1%b%b (scenario %0d)", t, {got, rid, rok}, id, exp_ok, scen);
            else passes++;
            checks++;
            if (rmac !== exp_mac) $display("[TB] FAIL rand_%0d_mac: got %h, expected %h", t, rmac, exp_mac);
            else passes++;
            checks++;
            if (arps !== exp_arps) $display("[TB] FAIL rand_%0d_arp_count: got %0d, expected %0d", t, arps, exp_arps);
            else passes++;
            if (scen == 0) begin
                checks++;
                if (lat !== 3) $display("[TB] FAIL rand_%0d_latency: got %0d, expected 3", t, lat);
                else passes++;
            end
        end
        table_silent = 0;
        decoy_en = 0;
    endtask

    initial begin
        i_rst = 1'b0;
        i_req0_valid = 1'b0;
        i_req0_ip = 32'h0;
        i_req1_valid = 1'b0;
        i_req1_ip = 32'h0;
        @(posedge i_clk);
        #1;
        test_reset();
        test_hit();
        test_miss_reply();
        test_timeout();
        test_filter_tie();
        test_arbitration();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
